// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide sequencer.
// Op encoding mirrors RV32M funct3 so ID/EX can pass it straight through.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } md_state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
    localparam logic [XLEN-1:0] SIGNED_OVF_Q  = {1'b1, {(XLEN-1){1'b0}}};

    // Two's-complement magnitude; 0x80000000 comes out as unsigned 2^31.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
        return s ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// ID/EX <-> muldiv sequencer port bundle; master is the pipeline, slave is the sequencer.
interface ex_muldiv_seq_if;
    import muldiv_pkg::*;

    logic            md_start;
    logic [2:0]      md_funct3;
    logic [XLEN-1:0] md_opa;
    logic [XLEN-1:0] md_opb;
    logic            md_flush;
    logic            md_stall;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    modport master (
        output md_start, md_funct3, md_opa, md_opb, md_flush,
        input  md_stall, md_done, md_result
    );

    modport slave (
        input  md_start, md_funct3, md_opa, md_opb, md_flush,
        output md_stall, md_done, md_result
    );

endinterface

// File: rtl/muldiv_iter_dp.sv
// Radix-2 shift-add multiply / restoring divide datapath, one bit per step.
// {hi,lo} is the product for multiply; hi=remainder, lo=dividend->quotient for divide.
module muldiv_iter_dp
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] ld_hi,
    input  logic [XLEN-1:0] ld_lo,
    input  logic [XLEN-1:0] ld_b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    logic [XLEN-1:0] b;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    always_comb begin
        add_sum = {1'b0, hi} + {1'b0, b};
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, b};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
            b  <= '0;
        end else if (load) begin
            hi <= ld_hi;
            lo <= ld_lo;
            b  <= ld_b;
        end else if (step) begin
            if (is_div) begin
                // diff[XLEN] is the borrow: set means the trial subtract failed
                if (!diff[XLEN]) begin
                    hi <= diff[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], 1'b1};
                end else begin
                    hi <= shifted[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], 1'b0};
                end
            end else if (lo[0]) begin
                {hi, lo} <= {add_sum, lo[XLEN-1:1]};
            end else begin
                {hi, lo} <= {1'b0, hi, lo[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M iterative mul/div sequencer: stalls ID/EX for 33 cycles (1 on div-by-zero/overflow),
// then pulses md_done with the sign-corrected result for the EX/MEM latch.
module ex_muldiv_seq
    import muldiv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    ex_muldiv_seq_if.slave md
);
    md_state_e         state;
    md_op_e            op;
    logic [CNT_W-1:0]  cnt;
    logic              neg;
    logic [XLEN-1:0]   res_q;

    md_op_e            in_op;
    logic              sa, sb, dbz, ovf, fast, accept, neg_in;
    logic [XLEN-1:0]   ld_hi, ld_lo, ld_b, hi, lo, fix;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        in_op = md_op_e'(md.md_funct3);
        sa    = 1'b0;
        sb    = 1'b0;
        case (in_op)
            OP_MULH, OP_DIV, OP_REM: begin
                sa = md.md_opa[XLEN-1];
                sb = md.md_opb[XLEN-1];
            end
            OP_MULHSU: sa = md.md_opa[XLEN-1];
            default: ;
        endcase
        dbz    = md.md_funct3[2] && (md.md_opb == '0);
        ovf    = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                 (md.md_opa == SIGNED_OVF_Q) && (md.md_opb == '1);
        fast   = dbz || ovf;
        neg_in = !fast && ((in_op == OP_REM) ? sa : (sa ^ sb));
        // Fast-path results are preloaded so the normal fix-up passes them through unchanged
        ld_hi  = dbz ? md.md_opa : '0;
        ld_lo  = dbz ? DIV_BY_ZERO_Q : (ovf ? SIGNED_OVF_Q : mag(md.md_opa, sa));
        ld_b   = mag(md.md_opb, sb);
        accept = (state == IDLE) && md.md_start && !md.md_flush;
    end

    muldiv_iter_dp u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (state == CALC),
        .is_div (op >= OP_DIV),
        .ld_hi  (ld_hi),
        .ld_lo  (ld_lo),
        .ld_b   (ld_b),
        .hi     (hi),
        .lo     (lo)
    );

    always_comb begin
        prod = neg ? (~{hi, lo} + 1'b1) : {hi, lo};
        case (op)
            OP_MUL:                      fix = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix = mag(lo, neg);
            default:                     fix = mag(hi, neg);
        endcase
    end

    assign md.md_stall  = accept || ((state == CALC) && !md.md_flush);
    assign md.md_done   = (state == DONE) && !md.md_flush;
    assign md.md_result = (state == DONE) ? fix : res_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            op    <= OP_MUL;
            cnt   <= '0;
            neg   <= 1'b0;
            res_q <= '0;
        end else if (md.md_flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (md.md_start) begin
                    op  <= in_op;
                    neg <= neg_in;
                    if (fast) begin
                        state <= DONE;
                    end else begin
                        state <= CALC;
                        cnt   <= CNT_W'(XLEN);
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= DONE;
                end
                default: begin
                    res_q <= fix;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for ex_muldiv_seq: directed RV32M cases, flush/reset aborts and random ops vs arithmetic model.
module tb_ex_muldiv_seq;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_muldiv_seq_if mdif ();

    ex_muldiv_seq dut (
        .clk (clk),
        .rst (rst),
        .md  (mdif)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          si, sj;
        bit          ovf;
        si  = $signed(a);
        sj  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        up  = {32'b0, a} * {32'b0, b};
        case (f)
            3'd0: return up[31:0];
            3'd1: begin sp = longint'(si) * longint'(sj);          return sp[63:32]; end
            3'd2: begin sp = longint'(si) * longint'({32'b0, b});  return sp[63:32]; end
            3'd3: return up[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(si / sj);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(si % sj);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Presents one op with start held until md_done, then checks latency, stall and result.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int          n;
        bit          stall_ok;
        logic [31:0] exp;
        int          exp_lat;
        string       id;
        exp     = ref_md(f, a, b);
        exp_lat = is_fast(f, a, b) ? 1 : 33;
        id      = $sformatf("f3=%0d a=%h b=%h", f, a, b);
        @(negedge clk);
        mdif.md_start  = 1'b1;
        mdif.md_funct3 = f;
        mdif.md_opa    = a;
        mdif.md_opb    = b;
        #1;
        chk({"done_single ", id}, 32'(mdif.md_done), 32'd0);
        chk({"stall_accept ", id}, 32'(mdif.md_stall), 32'd1);
        @(posedge clk);
        n        = 0;
        stall_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            #1;
            if (!mdif.md_done && !mdif.md_stall) stall_ok = 1'b0;
        end while (!mdif.md_done && n < 60);
        chk({"stall_busy ", id}, 32'(stall_ok), 32'd1);
        chk({"done_seen ", id}, 32'(mdif.md_done), 32'd1);
        chk({"latency ", id}, 32'(n), 32'(exp_lat));
        chk({"stall_at_done ", id}, 32'(mdif.md_stall), 32'd0);
        chk({"result ", id}, mdif.md_result, exp);
    endtask

    task automatic idle_watch(input string tag, input int k);
        bit seen;
        seen = 1'b0;
        repeat (k) begin
            @(negedge clk);
            mdif.md_start = 1'b0;
            mdif.md_flush = 1'b0;
            #1;
            if (mdif.md_done || mdif.md_stall) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    task automatic start_and_wait(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int k);
        @(negedge clk);
        mdif.md_start  = 1'b1;
        mdif.md_funct3 = f;
        mdif.md_opa    = a;
        mdif.md_opb    = b;
        @(posedge clk);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        mdif.md_start  = 1'b0;
        mdif.md_funct3 = 3'd0;
        mdif.md_opa    = '0;
        mdif.md_opb    = '0;
        mdif.md_flush  = 1'b0;
        rst            = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 32'(mdif.md_stall), 32'd0);
        chk("reset_done", 32'(mdif.md_done), 32'd0);
        chk("reset_result", mdif.md_result, 32'd0);
        rst = 1'b1;

        run_op(3'd0, 32'd7, 32'd6);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'd100, 32'd7);
        run_op(3'd7, 32'd100, 32'd7);
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd7, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        idle_watch("idle_after_directed", 2);

        // Flush mid-CALC aborts the DIV with no done pulse
        start_and_wait(3'd4, 32'd1000, 32'd3, 10);
        mdif.md_flush = 1'b1;
        mdif.md_start = 1'b0;
        #1;
        chk("flush_stall", 32'(mdif.md_stall), 32'd0);
        chk("flush_done", 32'(mdif.md_done), 32'd0);
        idle_watch("flush_no_done", 40);
        run_op(3'd0, 32'd3, 32'd3);
        idle_watch("idle_after_flush_mul", 1);

        // Flush coincident with start in IDLE: not accepted
        @(negedge clk);
        mdif.md_start  = 1'b1;
        mdif.md_flush  = 1'b1;
        mdif.md_funct3 = 3'd0;
        #1;
        chk("flush_start_stall", 32'(mdif.md_stall), 32'd0);
        idle_watch("flush_start_no_op", 40);

        // Reset pulse mid-op behaves as a full reset
        start_and_wait(3'd5, 32'd12345, 32'd17, 5);
        rst           = 1'b0;
        mdif.md_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_stall", 32'(mdif.md_stall), 32'd0);
        chk("midrst_done", 32'(mdif.md_done), 32'd0);
        chk("midrst_result", mdif.md_result, 32'd0);
        idle_watch("midrst_no_done", 40);

        // Back-to-back and randomized ops
        run_op(3'd0, 32'd11, 32'd13);
        run_op(3'd5, 32'd50, 32'd0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(f, a, b);
            if ($urandom_range(0, 1) == 1) idle_watch("rand_gap", 1);
        end
        idle_watch("final_idle", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
